// File: rtl/rr_arbiter8way16.sv
// Round-robin arbiter that shares one 16-bit bus among eight requesters A..H through an internal 8-way mux.
// Optional build macro: ARB_TIMEOUT_EN. When it is defined, a holder is forced off the bus after MAX_HOLD cycles if others wait.

module mux8way16 (
  input  logic [2:0]  sel_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [15:0] c_i,
  input  logic [15:0] d_i,
  input  logic [15:0] e_i,
  input  logic [15:0] f_i,
  input  logic [15:0] g_i,
  input  logic [15:0] h_i,
  output logic [15:0] y_o
);
  logic [15:0] in_w     [8];
  logic [15:0] masked_w [8];

  assign in_w[0] = a_i;
  assign in_w[1] = b_i;
  assign in_w[2] = c_i;
  assign in_w[3] = d_i;
  assign in_w[4] = e_i;
  assign in_w[5] = f_i;
  assign in_w[6] = g_i;
  assign in_w[7] = h_i;

  // AND-OR mux: exactly one leg is enabled by the decoded select.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_leg
      assign masked_w[gi] = (sel_i == 3'(gi)) ? in_w[gi] : 16'h0000;
    end
  endgenerate

  always_comb begin
    y_o = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      y_o = y_o | masked_w[k];
    end
  end
endmodule

module rr_arbiter8way16 #(
  parameter int MAX_HOLD = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  REQ,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] C,
  input  logic [15:0] D,
  input  logic [15:0] E,
  input  logic [15:0] F,
  input  logic [15:0] G,
  input  logic [15:0] H,
  output logic [7:0]  GNT,
  output logic [2:0]  SEL,
  output logic        VALID,
  output logic [15:0] Y
);
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t      state_q;
  logic [7:0]  gnt_q;
  logic [2:0]  sel_q;
  logic [2:0]  ptr_q;
  logic [3:0]  hold_q;

  logic [7:0]  req_others_w;
  logic [3:0]  pick_idle_w;
  logic [3:0]  pick_next_w;
  logic        release_w;
  logic        timeout_w;
  logic [15:0] mux_y_w;

  // Returns {found, index} of the first set bit scanning start, start+1, ... with wrap.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] start);
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [3:0]  res;
    dbl = {req, req};
    rot = dbl[start +: 8];
    res = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      if (rot[k]) res = {1'b1, start + 3'(k)};
    end
    return res;
  endfunction

  assign req_others_w = REQ & ~(8'd1 << sel_q);
  assign pick_idle_w  = rr_pick(REQ, ptr_q);
  assign pick_next_w  = rr_pick(req_others_w, sel_q + 3'd1);
  assign release_w    = ~REQ[sel_q];

`ifdef ARB_TIMEOUT_EN
  assign timeout_w = REQ[sel_q] && (hold_q == 4'(MAX_HOLD)) && (|req_others_w);
`else
  assign timeout_w = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      gnt_q   <= 8'h00;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
      hold_q  <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|REQ) begin
            state_q <= ST_BUSY;
            gnt_q   <= 8'd1 << pick_idle_w[2:0];
            sel_q   <= pick_idle_w[2:0];
            hold_q  <= 4'd1;
          end
        end
        ST_BUSY: begin
          if (release_w || timeout_w) begin
            // Holder moves to the back of the order; hand over on this same edge.
            ptr_q <= sel_q + 3'd1;
            if (pick_next_w[3]) begin
              gnt_q  <= 8'd1 << pick_next_w[2:0];
              sel_q  <= pick_next_w[2:0];
              hold_q <= 4'd1;
            end else begin
              state_q <= ST_IDLE;
              gnt_q   <= 8'h00;
              hold_q  <= 4'd0;
            end
          end else if (hold_q != 4'(MAX_HOLD)) begin
            hold_q <= hold_q + 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= 8'h00;
        end
      endcase
    end
  end

  mux8way16 u_mux (
    .sel_i (sel_q),
    .a_i   (A),
    .b_i   (B),
    .c_i   (C),
    .d_i   (D),
    .e_i   (E),
    .f_i   (F),
    .g_i   (G),
    .h_i   (H),
    .y_o   (mux_y_w)
  );

  assign GNT   = gnt_q;
  assign SEL   = sel_q;
  assign VALID = |gnt_q;
  assign Y     = VALID ? mux_y_w : 16'h0000;
endmodule
